// File: rtl/uart_tx_arb_if.sv
// Handshake bundle between UART requesters, the arbiter and the transmitter.
// The arbiter takes the slave view; the environment driving it takes the master view.
interface uart_tx_arb_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_PORTS  = 4
);
  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_PORTS-1:0]            s_axis_tvalid;
  logic [NUM_PORTS-1:0]            s_axis_tlast;
  logic [NUM_PORTS-1:0]            s_axis_tready;
  logic [DATA_WIDTH-1:0]           m_axis_tdata;
  logic                            m_axis_tvalid;
  logic                            m_axis_tready;
  logic                            tx_busy;
  logic [NUM_PORTS-1:0]            grant;
  logic [2:0]                      grant_id;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready, tx_busy,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, grant, grant_id
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready, tx_busy,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, grant, grant_id
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter multiplexing several byte streams onto one UART transmitter,
// with a single-register output stage, burst limiting and optional drain-to-idle.
module uart_tx_arb #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned WAIT_IDLE  = 1
) (
  input logic            clk,
  input logic            rst,
  uart_tx_arb_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [NUM_PORTS-1:0]    grant_q, grant_d;
  logic [2:0]              gid_q, gid_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    mvalid_q, mvalid_d;
  logic [DATA_WIDTH-1:0]   mdata_q, mdata_d;

  logic                    slot_free;
  logic                    accept;
  logic                    sel_last;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [NUM_PORTS-1:0]    ready_vec;
  logic                    pick_found;
  logic [2:0]              pick_id;
  logic [NUM_PORTS-1:0]    pick_oh;

  always_comb begin
    slot_free = !mvalid_q || bus.m_axis_tready;
    ready_vec = (state_q == XFER && slot_free) ? grant_q : '0;
    accept    = |(ready_vec & bus.s_axis_tvalid);
    sel_data  = '0;
    sel_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant_q[i]) begin
        sel_data = bus.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_last = bus.s_axis_tlast[i];
      end
    end
  end

  // Search starts just after the last grant: first ports above grant_id,
  // then wrap to ports 0..grant_id.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = gid_q;
    pick_oh    = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!pick_found && bus.s_axis_tvalid[i] && i > 32'(gid_q)) begin
        pick_found = 1'b1;
        pick_id    = 3'(i);
        pick_oh    = '0;
        pick_oh[i] = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!pick_found && bus.s_axis_tvalid[i] && i <= 32'(gid_q)) begin
        pick_found = 1'b1;
        pick_id    = 3'(i);
        pick_oh    = '0;
        pick_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gid_d    = gid_q;
    cnt_d    = cnt_q;
    mvalid_d = mvalid_q;
    mdata_d  = mdata_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_oh;
          gid_d   = pick_id;
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (accept) begin
          cnt_d = cnt_q + 8'd1;
          if (sel_last || (cnt_q + 8'd1) == 8'(MAX_BURST)) begin
            grant_d = '0;
            state_d = (WAIT_IDLE != 0) ? DRAIN : IDLE;
          end
        end
      end
      DRAIN: begin
        if (!mvalid_q && !bus.tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      mvalid_d = 1'b1;
      mdata_d  = sel_data;
    end else if (bus.m_axis_tready) begin
      mvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gid_q    <= 3'(NUM_PORTS - 1);
      cnt_q    <= '0;
      mvalid_q <= 1'b0;
      mdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gid_q    <= gid_d;
      cnt_q    <= cnt_d;
      mvalid_q <= mvalid_d;
      mdata_q  <= mdata_d;
    end
  end

  assign bus.s_axis_tready = ready_vec;
  assign bus.m_axis_tdata  = mdata_q;
  assign bus.m_axis_tvalid = mvalid_q;
  assign bus.grant         = grant_q;
  assign bus.grant_id      = gid_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: per-port source memories, an output/grant
// monitor sampled on the falling edge, and hand-computed expected sequences.
module tb_uart_tx_arb;
  localparam int unsigned DW = 8;
  localparam int unsigned NP = 4;

  logic clk = 1'b0;
  logic rst;

  uart_tx_arb_if #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) bus ();

  uart_tx_arb #(
    .DATA_WIDTH(DW),
    .NUM_PORTS (NP),
    .MAX_BURST (16),
    .WAIT_IDLE (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned n_acc  = 0;

  logic [8:0]  src_mem [NP][64];
  int unsigned rd [NP];
  int unsigned wr [NP];

  logic [DW-1:0] out_q [$];
  logic [NP-1:0] gnt_q [$];
  logic [NP-1:0] prev_grant = '0;

  always @(negedge clk) begin
    if (bus.m_axis_tvalid && bus.m_axis_tready) out_q.push_back(bus.m_axis_tdata);
    if (bus.grant != prev_grant && bus.grant != '0) gnt_q.push_back(bus.grant);
    prev_grant <= bus.grant;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] out_at(input int unsigned k);
    if (k < out_q.size()) return 32'(out_q[k]);
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] gnt_at(input int unsigned k);
    if (k < gnt_q.size()) return 32'(gnt_q[k]);
    return 32'hDEAD_BEEF;
  endfunction

  task automatic present();
    for (int i = 0; i < NP; i++) begin
      if (rd[i] < wr[i]) begin
        bus.s_axis_tvalid[i]           = 1'b1;
        bus.s_axis_tdata[i*DW +: DW]   = src_mem[i][rd[i]][7:0];
        bus.s_axis_tlast[i]            = src_mem[i][rd[i]][8];
      end else begin
        bus.s_axis_tvalid[i]           = 1'b0;
        bus.s_axis_tdata[i*DW +: DW]   = '0;
        bus.s_axis_tlast[i]            = 1'b0;
      end
    end
  endtask

  task automatic push(input int unsigned p, input logic [7:0] d, input logic last);
    src_mem[p][wr[p]] = {last, d};
    wr[p]++;
    present();
  endtask

  // One clock: handshakes are sampled mid-cycle, sources advance just after the edge.
  task automatic step();
    logic [NP-1:0] acc;
    @(negedge clk);
    acc = bus.s_axis_tready & bus.s_axis_tvalid;
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) begin
      if (acc[i]) begin
        rd[i]++;
        n_acc++;
      end
    end
    present();
  endtask

  task automatic wait_out(input int unsigned n, input int unsigned budget, input string tag);
    int unsigned c = 0;
    while (out_q.size() < n && c < budget) begin
      step();
      c++;
    end
    if (out_q.size() < n) check(tag, 32'(out_q.size()), 32'(n));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < NP; i++) begin
      rd[i] = 0;
      wr[i] = 0;
    end
    present();
    bus.m_axis_tready = 1'b1;
    bus.tx_busy       = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned ob, gb, nz, c;
    logic [DW-1:0] d0;
    int unsigned a0;

    rst = 1'b1;
    bus.m_axis_tready = 1'b0;
    bus.tx_busy       = 1'b0;
    for (int i = 0; i < NP; i++) begin
      rd[i] = 0;
      wr[i] = 0;
    end
    present();
    #1 rst = 1'b0;
    #2;
    check("rst_grant",    32'(bus.grant),         0);
    check("rst_grant_id", 32'(bus.grant_id),      3);
    check("rst_mvalid",   32'(bus.m_axis_tvalid), 0);
    check("rst_mdata",    32'(bus.m_axis_tdata),  0);
    check("rst_tready",   32'(bus.s_axis_tready), 0);
    do_reset();

    // Two-beat message from port 0
    ob = out_q.size();
    gb = gnt_q.size();
    push(0, 8'h11, 1'b0);
    push(0, 8'h22, 1'b1);
    wait_out(ob + 2, 20, "t1_timeout");
    check("t1_b0", out_at(ob), 32'h11);
    check("t1_b1", out_at(ob + 1), 32'h22);
    check("t1_grant", gnt_at(gb), 32'h1);
    repeat (4) step();
    check("t1_grant_clr", 32'(bus.grant), 0);
    check("t1_out_count", 32'(out_q.size() - ob), 2);
    check("t1_gnt_count", 32'(gnt_q.size() - gb), 1);

    // All four ports request single-beat messages at once
    do_reset();
    ob = out_q.size();
    gb = gnt_q.size();
    for (int p = 0; p < NP; p++) push(p, 8'(8'hA0 + p), 1'b1);
    wait_out(ob + 4, 60, "t2_timeout");
    for (int p = 0; p < NP; p++) begin
      check($sformatf("t2_out%0d", p), out_at(ob + p), 32'hA0 + p);
      check($sformatf("t2_gnt%0d", p), gnt_at(gb + p), 32'(1) << p);
    end
    check("t2_grant_id", 32'(bus.grant_id), 3);

    // Burst limit: port 2 streams 20 beats, port 1 joins after grant
    do_reset();
    ob = out_q.size();
    gb = gnt_q.size();
    for (int k = 0; k < 20; k++) push(2, 8'(8'h40 + k), 1'b0);
    repeat (3) step();
    push(1, 8'h99, 1'b1);
    wait_out(ob + 21, 200, "t3_timeout");
    for (int k = 0; k < 21; k++) begin
      if (k < 16)       check($sformatf("t3_seq%0d", k), out_at(ob + k), 32'h40 + k);
      else if (k == 16) check($sformatf("t3_seq%0d", k), out_at(ob + k), 32'h99);
      else              check($sformatf("t3_seq%0d", k), out_at(ob + k), 32'h40 + k - 1);
    end
    check("t3_gnt0", gnt_at(gb),     32'h4);
    check("t3_gnt1", gnt_at(gb + 1), 32'h2);
    check("t3_gnt2", gnt_at(gb + 2), 32'h4);
    repeat (5) step();
    check("t3_hold_grant",  32'(bus.grant),         32'h4);
    check("t3_hold_tready", 32'(bus.s_axis_tready), 32'h4);

    // Transmitter stalls for 5 cycles mid-message
    do_reset();
    ob = out_q.size();
    for (int k = 0; k < 10; k++) push(0, 8'(8'h60 + k), k == 9);
    wait_out(ob + 3, 30, "t4_timeout_a");
    bus.m_axis_tready = 1'b0;
    d0 = bus.m_axis_tdata;
    a0 = n_acc;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t4_mvalid", 32'(bus.m_axis_tvalid), 1);
      check("t4_hold",   32'(bus.m_axis_tdata),  32'(d0));
      check("t4_tready", 32'(bus.s_axis_tready), 0);
    end
    check("t4_acc", n_acc, a0);
    bus.m_axis_tready = 1'b1;
    wait_out(ob + 10, 40, "t4_timeout_b");
    for (int k = 0; k < 10; k++) check($sformatf("t4_seq%0d", k), out_at(ob + k), 32'h60 + k);

    // Re-arbitration held while transmitter stays busy
    do_reset();
    bus.tx_busy = 1'b1;
    ob = out_q.size();
    gb = gnt_q.size();
    push(0, 8'hB0, 1'b1);
    push(3, 8'hB3, 1'b1);
    wait_out(ob + 1, 20, "t5_timeout_a");
    nz = 0;
    repeat (30) begin
      step();
      if (bus.grant != '0) nz++;
    end
    check("t5_grant_busy", nz, 0);
    bus.tx_busy = 1'b0;
    step();
    check("t5_grant_drain", 32'(bus.grant), 0);
    step();
    check("t5_grant_p3", 32'(bus.grant), 32'h8);
    wait_out(ob + 2, 20, "t5_timeout_b");
    check("t5_b0", out_at(ob), 32'hB0);
    check("t5_b1", out_at(ob + 1), 32'hB3);

    // Asynchronous reset in the middle of a port 1 message
    do_reset();
    for (int k = 0; k < 5; k++) push(1, 8'(8'h70 + k), k == 4);
    c = 0;
    while (!(bus.grant == 4'b0010 && bus.m_axis_tvalid) && c < 20) begin
      step();
      c++;
    end
    check("t6_inflight", 32'(bus.grant == 4'b0010 && bus.m_axis_tvalid), 1);
    #2 rst = 1'b0;
    #1;
    check("t6_grant",    32'(bus.grant),         0);
    check("t6_mvalid",   32'(bus.m_axis_tvalid), 0);
    check("t6_mdata",    32'(bus.m_axis_tdata),  0);
    check("t6_tready",   32'(bus.s_axis_tready), 0);
    check("t6_grant_id", 32'(bus.grant_id),      3);
    do_reset();
    ob = out_q.size();
    gb = gnt_q.size();
    push(3, 8'hC3, 1'b1);
    push(0, 8'hC0, 1'b1);
    wait_out(ob + 2, 40, "t6_timeout");
    check("t6_first_gnt", gnt_at(gb), 32'h1);
    check("t6_b0", out_at(ob), 32'hC0);
    check("t6_b1", out_at(ob + 1), 32'hC3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the byte width of every data port.
REQ-002 Parameter NUM_PORTS, default 4, range 2..8, SHALL set the number of requester ports.
REQ-003 Parameter MAX_BURST, default 16, range 1..255, SHALL set the maximum beats per grant before the grant is forcibly released.
REQ-004 Parameter WAIT_IDLE, default 1, SHALL make the block hold re-arbitration until the transmitter is idle when set to 1.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  SHALL be an asynchronous, active-low reset.
REQ-007 s_axis_tdata  input  NUM_PORTS*DATA_WIDTH  SHALL carry requester data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 s_axis_tvalid  input  NUM_PORTS  SHALL carry per-port valid.
REQ-009 s_axis_tlast  input  NUM_PORTS  SHALL mark the per-port end of message.
REQ-010 s_axis_tready  output  NUM_PORTS  SHALL carry per-port ready.
REQ-011 m_axis_tdata  output  DATA_WIDTH  SHALL carry the byte to the UART transmitter.
REQ-012 m_axis_tvalid  output  1  SHALL be the transmitter-side valid.
REQ-013 m_axis_tready  input  1  SHALL be the transmitter-side ready.
REQ-014 tx_busy  input  1  SHALL be the transmitter busy flag.
REQ-015 grant  output  NUM_PORTS  SHALL be a one-hot registered grant, all-zero when no port is granted.
REQ-016 grant_id  output  3  SHALL be the binary index of the last granted port.

Function
REQ-017 States SHALL be IDLE, XFER and DRAIN.
REQ-018 In IDLE with any s_axis_tvalid bit high, the block SHALL select round-robin, starting at port (grant_id+1) mod NUM_PORTS, set grant and grant_id at the next edge, and enter XFER.
REQ-019 In IDLE with no valid bits high, grant SHALL stay zero and the round-robin pointer SHALL hold.
REQ-020 The output stage SHALL be a single register; "slot free" SHALL be (!m_axis_tvalid || m_axis_tready).
REQ-021 s_axis_tready[i] SHALL be grant[i] && state==XFER && slot free (combinational); it SHALL be 0 for all ungranted ports.
REQ-022 A beat accepted on port i at edge N SHALL appear on m_axis_tdata with m_axis_tvalid=1 after edge N (1-cycle latency), with no duplication or loss.
REQ-023 m_axis_tvalid SHALL drop after an edge where m_axis_tready=1 and no new beat is accepted; m_axis_tdata SHALL hold while m_axis_tvalid=1 and m_axis_tready=0.
REQ-024 An 8-bit beat counter SHALL clear on grant and increment per accepted beat.
REQ-025 XFER SHALL exit on an accepted beat with tlast=1 or with counter reaching MAX_BURST: to DRAIN if WAIT_IDLE=1, otherwise to IDLE; grant SHALL clear at that edge.
REQ-026 DRAIN SHALL return to IDLE when m_axis_tvalid==0 and tx_busy==0.
REQ-027 If the granted port deasserts tvalid mid-message, the block SHALL remain in XFER holding the grant (no timeout).
REQ-028 Simultaneous requests SHALL be resolved strictly by REQ-018; a port SHALL never be granted twice in a row while another port is requesting in IDLE.

Reset
REQ-029 On rst low, the block SHALL immediately set state=IDLE, grant=0, grant_id=NUM_PORTS-1, m_axis_tvalid=0, m_axis_tdata=0, beat counter=0, and s_axis_tready=0, independent of clk.
REQ-030 Reset asserted mid-message SHALL discard the in-flight registered beat; after release the first grant SHALL go to port 0.

Verification
REQ-031 Port 0 sends 0x11,0x22 (tlast on 0x22), m_axis_tready=1, tx_busy=0 -> m_axis sees exactly 0x11,0x22; grant 0001 then 0000.
REQ-032 Ports 0..3 all valid with single-beat tlast messages 0xA0..0xA3 -> output order 0xA0,0xA1,0xA2,0xA3; grant_id 0,1,2,3.
REQ-033 Port 2 streams 20 beats without tlast, MAX_BURST=16, port 1 also valid -> 16 beats from port 2, then port 1 granted, then port 2 resumes with beat 17.
REQ-034 m_axis_tready held 0 for 5 cycles mid-message -> m_axis_tdata stable, s_axis_tready=0, accept count unchanged; on release, no byte duplicated or dropped.
REQ-035 WAIT_IDLE=1, tx_busy held 1 for 30 cycles after tlast with port 3 valid -> grant stays 0 until 1 cycle after tx_busy falls.
REQ-036 rst pulsed low mid-message from port 1 -> all outputs zero without a clock edge; first post-reset grant goes to port 0.
